id_pattern_gen: RTL

ID_PATTERN_GEN -- requirements
Module: id_pattern_gen

---
 rtl/calib_pkg.sv | 36 +++
 rtl/id_palette.sv | 50 +++++
 rtl/id_pattern_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/calib_pkg.sv
// Shared types, palette constants and frame-count helper for the LED ID pattern generator.
// Compile-time option: ID_PARITY_EN adds one parity frame after the data frames.
package calib_pkg;

  typedef enum logic [1:0] {
    MODE_ID        = 2'd0,
    MODE_WHITE     = 2'd1,
    MODE_BLACK     = 2'd2,
    MODE_BLACK_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_RESPOND
  } state_e;

  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;

`ifdef ID_PARITY_EN
  localparam int PARITY_FRAMES = 1;
`else
  localparam int PARITY_FRAMES = 0;
`endif

  // Number of frames needed to show idWidth bits, bitsPerFrame at a time, plus any extra frames.
  function automatic int num_frames(input int idWidth, input int bitsPerFrame, input int extra);
    return (idWidth + bitsPerFrame - 1) / bitsPerFrame + extra;
  endfunction

endpackage

// File: rtl/id_palette.sv
// Combinational colour lookup: digit, mode and (optionally) parity to 24-bit RGB.
// Compile-time option: ID_PARITY_EN adds the parity-select and parity inputs.
module id_palette
  import calib_pkg::*;
#(
  parameter int BITS_PER_FRAME = 1
) (
  input  logic [1:0]  i_digit,
  input  mode_e       i_mode,
  input  logic        i_outOfRange,
`ifdef ID_PARITY_EN
  input  logic        i_paritySel,
  input  logic        i_parityOdd,
`endif
  output logic [23:0] o_rgb
);

  // Out-of-range indices are always dark; otherwise parity, forced modes, then the ID digit colour.
  always_comb begin
    o_rgb = RGB_BLACK;
    if (i_outOfRange) begin
      o_rgb = RGB_BLACK;
    end
`ifdef ID_PARITY_EN
    else if (i_paritySel) begin
      o_rgb = i_parityOdd ? RGB_MAGENTA : RGB_GREEN;
    end
`endif
    else begin
      case (i_mode)
        MODE_WHITE:     o_rgb = RGB_WHITE;
        MODE_BLACK:     o_rgb = RGB_BLACK;
        MODE_BLACK_ALT: o_rgb = RGB_BLACK;
        default: begin
          if (BITS_PER_FRAME == 1) begin
            o_rgb = i_digit[0] ? RGB_BLUE : RGB_RED;
          end else begin
            case (i_digit)
              2'd0:    o_rgb = RGB_RED;
              2'd1:    o_rgb = RGB_GREEN;
              2'd2:    o_rgb = RGB_BLUE;
              default: o_rgb = RGB_WHITE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/id_pattern_gen.sv
// LED ID pattern generator: answers per-pixel colour requests so that a camera can decode
// each LED's index one digit per frame. Supports manual and automatic frame stepping.
// Compile-time option: ID_PARITY_EN adds a parity frame (green = even, magenta = odd).
module id_pattern_gen
  import calib_pkg::*;
#(
  parameter int NUM_LEDS       = 50,
  parameter int ID_WIDTH       = $clog2(NUM_LEDS),
  parameter int BITS_PER_FRAME = 1,
  parameter int HOLD_PASSES    = 4,
  localparam int NUM_FRAMES    = num_frames(ID_WIDTH, BITS_PER_FRAME, PARITY_FRAMES),
  localparam int FRAME_W       = $clog2(NUM_FRAMES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ID_WIDTH-1:0] req_index,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [7:0]          px_red,
  output logic [7:0]          px_green,
  output logic [7:0]          px_blue,
  input  logic [1:0]          mode,
  input  logic                frame_next,
  input  logic                frame_prev,
  input  logic                auto_en,
  output logic [FRAME_W-1:0]  frame_idx,
  output logic                frame_done,
  output logic                sequence_done
);

  localparam int SW     = (ID_WIDTH < 2) ? 2 : ID_WIDTH;
  localparam int PASS_W = $clog2(HOLD_PASSES + 1);

  localparam logic [ID_WIDTH:0]   NUM_LEDS_W = (ID_WIDTH + 1)'(NUM_LEDS);
  localparam logic [ID_WIDTH-1:0] LAST_IDX   = ID_WIDTH'(NUM_LEDS - 1);
  localparam logic [FRAME_W-1:0]  LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [PASS_W-1:0]   LAST_PASS  = PASS_W'(HOLD_PASSES - 1);

  state_e              r_state;
  state_e              w_nextState;
  logic [SW-1:0]       r_shiftIdx;
  logic [ID_WIDTH-1:0] r_origIdx;
  logic [FRAME_W-1:0]  r_shiftCnt;
  mode_e               r_mode;
  logic                r_outOfRange;
  logic [PASS_W-1:0]   r_passCnt;

  logic                w_accept;
  logic                w_lastDone;
  logic                w_startDirect;
  logic [1:0]          w_digit;
  logic [23:0]         w_rgb;
  logic [FRAME_W-1:0]  w_frameInc;
  logic [FRAME_W-1:0]  w_frameDec;

`ifdef ID_PARITY_EN
  localparam int                 NUM_DATA_FRAMES = num_frames(ID_WIDTH, BITS_PER_FRAME, 0);
  localparam logic [FRAME_W-1:0] PARITY_FRAME    = FRAME_W'(NUM_DATA_FRAMES);

  logic r_paritySel;
  logic r_parityOdd;
  logic w_isParityFrame;

  assign w_isParityFrame = (frame_idx == PARITY_FRAME);
  assign w_startDirect   = (frame_idx == '0) || w_isParityFrame;
`else
  assign w_startDirect   = (frame_idx == '0);
`endif

  assign w_accept   = req_valid && req_ready;
  assign w_lastDone = px_valid && px_ready && (r_origIdx == LAST_IDX);
  assign w_digit    = (BITS_PER_FRAME == 1) ? {1'b0, r_shiftIdx[0]} : r_shiftIdx[1:0];
  assign w_frameInc = (frame_idx == LAST_FRAME) ? '0 : frame_idx + 1'b1;
  assign w_frameDec = (frame_idx == '0) ? LAST_FRAME : frame_idx - 1'b1;

  assign {px_red, px_green, px_blue} = px_valid ? w_rgb : RGB_BLACK;

  id_palette #(
    .BITS_PER_FRAME(BITS_PER_FRAME)
  ) u_palette (
    .i_digit      (w_digit),
    .i_mode       (r_mode),
    .i_outOfRange (r_outOfRange),
`ifdef ID_PARITY_EN
    .i_paritySel  (r_paritySel),
    .i_parityOdd  (r_parityOdd),
`endif
    .o_rgb        (w_rgb)
  );

  // Request FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs; ready is held low while reset is asserted.
  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    px_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          w_nextState = w_startDirect ? ST_RESPOND : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_shiftCnt == FRAME_W'(1)) begin
          w_nextState = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        px_valid = 1'b1;
        if (px_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Latch the request context at accept, then walk the index down one digit per shift cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shiftIdx   <= '0;
      r_origIdx    <= '0;
      r_shiftCnt   <= '0;
      r_mode       <= MODE_ID;
      r_outOfRange <= 1'b0;
`ifdef ID_PARITY_EN
      r_paritySel  <= 1'b0;
      r_parityOdd  <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_shiftIdx   <= SW'(req_index);
        r_origIdx    <= req_index;
        r_shiftCnt   <= frame_idx;
        r_mode       <= mode_e'(mode);
        r_outOfRange <= ({1'b0, req_index} >= NUM_LEDS_W);
`ifdef ID_PARITY_EN
        r_paritySel  <= w_isParityFrame;
        r_parityOdd  <= ^req_index;
`endif
      end else if (r_state == ST_SHIFT) begin
        r_shiftIdx <= r_shiftIdx >> BITS_PER_FRAME;
        r_shiftCnt <= r_shiftCnt - 1'b1;
      end
    end
  end

  // Frame index, completion flags and the auto-advance pass counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_idx     <= '0;
      frame_done    <= 1'b0;
      sequence_done <= 1'b0;
      r_passCnt     <= '0;
    end else begin
      sequence_done <= 1'b0;
      if (auto_en) begin
        if (w_lastDone) begin
          if (r_passCnt == LAST_PASS) begin
            r_passCnt  <= '0;
            frame_done <= 1'b0;
            frame_idx  <= w_frameInc;
            if (frame_idx == LAST_FRAME) begin
              sequence_done <= 1'b1;
            end
          end else begin
            r_passCnt  <= r_passCnt + 1'b1;
            frame_done <= 1'b1;
          end
        end
      end else begin
        r_passCnt <= '0;
        if (frame_next && !frame_prev) begin
          frame_idx  <= w_frameInc;
          frame_done <= 1'b0;
        end else if (frame_prev && !frame_next) begin
          frame_idx  <= w_frameDec;
          frame_done <= 1'b0;
        end else if (w_lastDone) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule
